// File: rtl/online_div_residue_seq.sv
// Purpose: iteration sequencer for the online divider residue store (w_plus/w_minus).
// Latency: one CLEAR cycle, then NUM_DIGITS+ONLINE_DELAY RUN steps, then a one-cycle DONE pulse.
// Backpressure: digit_in_valid stalls RUN while operand digits are consumed; the pad phase self-steps.
module online_div_residue_seq #(
    parameter int NUM_DIGITS   = 32,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  digit_in_valid,
    output logic                  digit_in_ready,
    output logic                  pad_zero,
    output logic                  mem_clear,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  warmup,
    output logic                  q_valid,
    output logic [CNT_WIDTH-1:0]  q_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Iteration bounds held at counter width so every compare is width-matched.
    localparam logic [CNT_WIDTH-1:0] LP_ND   = CNT_WIDTH'(NUM_DIGITS);
    localparam logic [CNT_WIDTH-1:0] LP_OD   = CNT_WIDTH'(ONLINE_DELAY);
    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUM_DIGITS + ONLINE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_j;

    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   w_j_nxt;
    logic [CNT_WIDTH-1:0]   w_j_inc;
    logic                   w_operand_phase;
    logic                   w_warm_phase;
    logic                   w_last_step;
    logic                   w_fire;

    assign w_j_inc         = r_j + LP_ONE;
    assign w_operand_phase = (r_j < LP_ND);
    assign w_warm_phase    = (r_j < LP_OD);
    assign w_last_step     = (r_j == LP_LAST);
    // Operand steps wait for the handshake; pad steps feed zero digits and never stall.
    assign w_fire          = w_operand_phase ? digit_in_valid : 1'b1;

    // State and iteration counter; reset wins over every other request.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
        end
    end

    // Next-state/counter logic and per-state outputs; everything is zero unless a state drives it.
    always_comb begin
        w_state_nxt    = r_state;
        w_j_nxt        = r_j;
        digit_in_ready = 1'b0;
        pad_zero       = 1'b0;
        mem_clear      = 1'b0;
        mem_enable     = 1'b0;
        rd_addr        = '0;
        wr_addr        = '0;
        warmup         = 1'b0;
        q_valid        = 1'b0;
        q_idx          = '0;
        busy           = 1'b0;
        done           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // start beats a simultaneous abort; abort alone is a no-op here.
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    w_j_nxt     = '0;
                end
            end

            S_CLEAR: begin
                // Seed residue slot 0 with zero before the first iteration reads it.
                busy       = 1'b1;
                mem_clear  = 1'b1;
                mem_enable = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_j_nxt     = '0;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                busy           = 1'b1;
                digit_in_ready = w_operand_phase;
                pad_zero       = !w_operand_phase;
                warmup         = w_warm_phase;
                mem_enable     = w_fire;
                // Step j reads the slot written by step j-1, keeping the residue chain contiguous.
                rd_addr        = ADDR_WIDTH'(r_j);
                wr_addr        = ADDR_WIDTH'(w_j_inc);
                q_valid        = w_fire && !w_warm_phase;
                q_idx          = q_valid ? (r_j - LP_OD) : '0;
                if (abort) begin
                    // Strobes above still reflect this cycle; the operation is dropped afterwards.
                    w_state_nxt = S_IDLE;
                    w_j_nxt     = '0;
                end else if (w_fire) begin
                    w_j_nxt = w_j_inc;
                    if (w_last_step) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy        = 1'b1;
                done        = !abort;
                w_state_nxt = S_IDLE;
                w_j_nxt     = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_j_nxt     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_online_div_residue_seq.sv
module tb_online_div_residue_seq;

    localparam int ND = 8;
    localparam int OD = 3;
    localparam int AW = 7;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic          start;
    logic          abort;
    logic          digit_in_valid;
    logic          digit_in_ready;
    logic          pad_zero;
    logic          mem_clear;
    logic          mem_enable;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          warmup;
    logic          q_valid;
    logic [CW-1:0] q_idx;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0;

    typedef logic [29:0] ov_t;
    ov_t w_obs;

    always #5 clk = ~clk;

    online_div_residue_seq #(
        .NUM_DIGITS  (ND),
        .ONLINE_DELAY(OD),
        .ADDR_WIDTH  (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .asyn_reset    (asyn_reset),
        .start         (start),
        .abort         (abort),
        .digit_in_valid(digit_in_valid),
        .digit_in_ready(digit_in_ready),
        .pad_zero      (pad_zero),
        .mem_clear     (mem_clear),
        .mem_enable    (mem_enable),
        .rd_addr       (rd_addr),
        .wr_addr       (wr_addr),
        .warmup        (warmup),
        .q_valid       (q_valid),
        .q_idx         (q_idx),
        .busy          (busy),
        .done          (done)
    );

    assign w_obs = {digit_in_ready, pad_zero, mem_clear, mem_enable, rd_addr, wr_addr,
                    warmup, q_valid, q_idx, busy, done};

    function automatic ov_t mk(input logic rdy, input logic pad, input logic clr, input logic en,
                               input int rd, input int wr, input logic warm, input logic qv,
                               input int qi, input logic bsy, input logic dn);
        logic [AW-1:0] a_rd;
        logic [AW-1:0] a_wr;
        logic [CW-1:0] a_qi;
        a_rd = rd[AW-1:0];
        a_wr = wr[AW-1:0];
        a_qi = qi[CW-1:0];
        return {rdy, pad, clr, en, a_rd, a_wr, warm, qv, a_qi, bsy, dn};
    endfunction

    function automatic ov_t exp_idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ov_t exp_clear();
        return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    function automatic ov_t exp_done();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0) | ov_t'(1);
    endfunction

    // Expected RUN outputs for step k with the given operand valid.
    function automatic ov_t exp_run(input int k, input logic v);
        logic f;
        logic qv;
        f  = (k < ND) ? v : 1'b1;
        qv = f && (k >= OD);
        return mk(k < ND, k >= ND, 0, f, k, k + 1, k < OD, qv, qv ? k - OD : 0, 1, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input ov_t exp);
        #1;
        checks++;
        assert (w_obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_steps(input string tag, input int k0, input int k1, input logic v);
        for (int k = k0; k <= k1; k++) begin
            digit_in_valid = v;
            chk($sformatf("%s_k%0d", tag, k), exp_run(k, v));
            tick();
        end
    endtask

    initial begin
        asyn_reset     = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        digit_in_valid = 1'b0;
        tick();
        tick();
        chk("reset_idle", exp_idle());
        asyn_reset = 1'b0;

        // Full run, valid held high.
        digit_in_valid = 1'b1;
        start          = 1'b1;
        chk("idle_with_start", exp_idle());
        tick();
        t0    = cyc - 1;
        start = 1'b0;
        chk("t1_clear", exp_clear());
        tick();
        run_steps("t1", 0, 10, 1'b1);
        chk("t1_done", exp_done());
        chk_int("t1_done_cycle", cyc - t0, 13);
        tick();
        chk("t1_idle_after", exp_idle());

        // Four-cycle stall at j=5.
        start = 1'b1;
        tick();
        t0    = cyc - 1;
        start = 1'b0;
        chk("t2_clear", exp_clear());
        tick();
        run_steps("t2", 0, 4, 1'b1);
        for (int s = 0; s < 4; s++) begin
            run_steps($sformatf("t2_stall%0d", s), 5, 5, 1'b0);
        end
        run_steps("t2", 5, 10, 1'b1);
        chk("t2_done", exp_done());
        chk_int("t2_done_cycle", cyc - t0, 17);
        tick();
        chk("t2_idle_after", exp_idle());

        // Pad phase self-steps with valid low.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_steps("t3", 0, 7, 1'b1);
        run_steps("t3_pad", 8, 10, 1'b0);
        chk("t3_done", exp_done());
        tick();
        chk("t3_idle_after", exp_idle());

        // start held through the whole run: one division, then a fresh CLEAR.
        digit_in_valid = 1'b1;
        start          = 1'b1;
        tick();
        chk("t4_clear", exp_clear());
        tick();
        run_steps("t4", 0, 10, 1'b1);
        chk("t4_done_start_ignored", exp_done());
        tick();
        chk("t4_idle_despite_start", exp_idle());
        tick();
        chk("t4_second_clear", exp_clear());
        start = 1'b0;
        abort = 1'b1;
        chk("t4_clear_abort_cycle", exp_clear());
        tick();
        abort = 1'b0;
        chk("t4_idle_after_abort", exp_idle());

        // abort alone in IDLE does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_idle_abort_noeffect", exp_idle());

        // abort at j=6.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_steps("t5", 0, 5, 1'b1);
        abort = 1'b1;
        chk("t5_abort_cycle_k6", exp_run(6, 1'b1));
        tick();
        abort = 1'b0;
        chk("t5_idle_after_abort", exp_idle());
        tick();
        chk("t5_no_done", exp_idle());

        // start and abort together in IDLE: start wins, restart from j=0.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_restart_clear", exp_clear());
        tick();
        run_steps("t6", 0, 3, 1'b1);

        // Synchronous reset at j=4 with start also high.
        asyn_reset = 1'b1;
        start      = 1'b1;
        chk("t6_k4_before_reset", exp_run(4, 1'b1));
        tick();
        asyn_reset = 1'b0;
        start      = 1'b0;
        chk("t6_idle_after_reset", exp_idle());
        tick();
        chk("t6_no_done_no_start", exp_idle());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
